// File: rtl/id_sb_pkg.sv
// Shared constants and helpers for the ID-stage scoreboarded register file.
package id_sb_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned DEF_CNT_W    = 2;
  localparam int unsigned ZERO_REG     = 0;

  // Register address width; never below one bit so ports stay legal.
  function automatic int unsigned id_sb_aw(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/id_scoreboard_regfile_if.sv
// ID-stage bus: operand reads, issue request/stall, writeback and kill.
interface id_scoreboard_regfile_if import id_sb_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned AW       = id_sb_aw(NUM_REGS)
);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD-1:0]        rd_used;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     issue_valid;
  logic                     issue_wr_en;
  logic [AW-1:0]            issue_wr_addr;
  logic                     issue_accept;
  logic                     stall;
  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     kill_valid;
  logic [AW-1:0]            kill_addr;
  logic                     err_underflow;

  modport master (
    output rd_addr, rd_used, issue_valid, issue_wr_en, issue_wr_addr,
           wb_valid, wb_addr, wb_data, kill_valid, kill_addr,
    input  rd_data, issue_accept, stall, err_underflow
  );

  modport slave (
    input  rd_addr, rd_used, issue_valid, issue_wr_en, issue_wr_addr,
           wb_valid, wb_addr, wb_data, kill_valid, kill_addr,
    output rd_data, issue_accept, stall, err_underflow
  );

endinterface

// File: rtl/id_sb_pending_ctr.sv
// Per-register pending-write counter: net inc/dec each cycle, clamps at 0
// (flagging underflow) and at all-ones.
module id_sb_pending_ctr #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow_c
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] up;
  logic [SUM_W-1:0] down;
  logic [SUM_W-1:0] net;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    up          = SUM_W'(cnt) + SUM_W'(inc);
    down        = SUM_W'(dec_wb) + SUM_W'(dec_kill);
    net         = up - down;
    cnt_d       = cnt;
    underflow_c = 1'b0;
    if (down > up) begin
      cnt_d       = '0;
      underflow_c = 1'b1;
    end else if (net > CNT_MAX) begin
      cnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      cnt_d = CNT_W'(net);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt <= '0;
    else       cnt <= cnt_d;
  end

endmodule

// File: rtl/id_scoreboard_regfile.sv
// Decode-stage register file with writeback bypass and per-register pending
// counters for stall. Optional perf counters under ID_SB_PERF_CNT_EN.
module id_scoreboard_regfile import id_sb_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  id_scoreboard_regfile_if.slave   bus
`ifdef ID_SB_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              raw_stalls
`endif
);

  localparam int unsigned AW = id_sb_aw(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW-1:0]    REG0    = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] uf;
  logic [NUM_RD-1:0]   hazard;
  logic                haz_any;
  logic                sat;
  logic                stall_c;
  logic                accept_c;
  logic                err_q;

  // Register 0 is never counted and never flags underflow.
  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    id_sb_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
      .Clk         (Clk),
      .Reset       (Reset),
      .inc         (accept_c & bus.issue_wr_en & (bus.issue_wr_addr == AW'(r))),
      .dec_wb      (bus.wb_valid & (bus.wb_addr == AW'(r))),
      .dec_kill    (bus.kill_valid & (bus.kill_addr == AW'(r))),
      .cnt         (cnt[r]),
      .underflow_c (uf[r])
    );
  end

  // Read ports: zero register, then same-cycle writeback, then the array.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] src;
    logic          src_zero;
    logic          src_wb;
    assign src      = bus.rd_addr[i*AW +: AW];
    assign src_zero = (src == REG0);
    assign src_wb   = bus.wb_valid & (bus.wb_addr == src);
    assign bus.rd_data[i*DATA_W +: DATA_W] = src_zero ? '0
                                           : src_wb   ? bus.wb_data
                                           : regs[src];
    // The final outstanding write arriving now is resolved via bypass.
    assign hazard[i] = bus.rd_used[i] & ~src_zero & (cnt[src] != '0) &
                       ~((cnt[src] == CNT_ONE) & src_wb);
  end

  assign haz_any  = |hazard;
  assign sat      = bus.issue_wr_en & (bus.issue_wr_addr != REG0) &
                    (cnt[bus.issue_wr_addr] == CNT_MAX);
  assign stall_c  = bus.issue_valid & (haz_any | sat);
  assign accept_c = bus.issue_valid & ~stall_c;

  assign bus.stall         = stall_c;
  assign bus.issue_accept  = accept_c;
  assign bus.err_underflow = err_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (bus.wb_valid && (bus.wb_addr != REG0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_q | (|uf);
  end

`ifdef ID_SB_PERF_CNT_EN
  // A cycle with both hazard and saturation counts as a hazard stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
    end else begin
      if (stall_c)                     stall_cycles <= stall_cycles + 32'd1;
      if (bus.issue_valid && haz_any)  raw_stalls   <= raw_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_scoreboard_regfile.sv
// Directed bench for id_scoreboard_regfile (default parameters, CNT_W = 2).
module tb_id_scoreboard_regfile;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;

  id_scoreboard_regfile_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .AW(5)) bus ();

`ifdef ID_SB_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] raw_stalls;
`endif

  id_scoreboard_regfile dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef ID_SB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .raw_stalls   (raw_stalls)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    bus.rd_addr       = '0;
    bus.rd_used       = '0;
    bus.issue_valid   = 1'b0;
    bus.issue_wr_en   = 1'b0;
    bus.issue_wr_addr = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_addr       = '0;
    bus.wb_data       = '0;
    bus.kill_valid    = 1'b0;
    bus.kill_addr     = '0;
    step();
    step();
    Reset = 1'b0;

    // Reset state, reads of r5/r7
    bus.rd_addr = {5'd7, 5'd5};
    bus.rd_used = 2'b11;
    bus.issue_valid = 1'b1;
    #1;
    chk("rst_rd_data", 64'(bus.rd_data), 64'h0);
    chk("rst_stall", 64'(bus.stall), 64'h0);
    chk("rst_err", 64'(bus.err_underflow), 64'h0);
    chk("rst_accept", 64'(bus.issue_accept), 64'h1);

    // RAW on r3 resolved by writeback bypass
    bus.rd_used = 2'b00;
    bus.issue_wr_en = 1'b1;
    bus.issue_wr_addr = 5'd3;
    #1;
    chk("r3_issue_accept", 64'(bus.issue_accept), 64'h1);
    step();
    bus.issue_wr_en = 1'b0;
    bus.rd_addr = {5'd0, 5'd3};
    bus.rd_used = 2'b01;
    #1;
    chk("r3_stall_c1", 64'(bus.stall), 64'h1);
    chk("r3_accept_c1", 64'(bus.issue_accept), 64'h0);
    step();
    chk("r3_stall_c2", 64'(bus.stall), 64'h1);
    bus.wb_valid = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("r3_wb_stall", 64'(bus.stall), 64'h0);
    chk("r3_wb_bypass", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    chk("r3_wb_accept", 64'(bus.issue_accept), 64'h1);
    step();
    bus.wb_valid = 1'b0;
    #1;
    chk("r3_array", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    chk("r3_no_stall", 64'(bus.stall), 64'h0);

    // Saturation on r4
    bus.rd_used = 2'b00;
    bus.issue_wr_en = 1'b1;
    bus.issue_wr_addr = 5'd4;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("r4_fill_accept", 64'(bus.issue_accept), 64'h1);
      step();
    end
    chk("r4_sat_stall", 64'(bus.stall), 64'h1);
    bus.wb_valid = 1'b1;
    bus.wb_addr = 5'd4;
    bus.wb_data = 32'h4444;
    #1;
    chk("r4_sat_wb_stall", 64'(bus.stall), 64'h1);
    step();
    bus.wb_valid = 1'b0;
    #1;
    chk("r4_fourth_accept", 64'(bus.issue_accept), 64'h1);
    step();
    chk("r4_resat_stall", 64'(bus.stall), 64'h1);
    bus.issue_valid = 1'b0;
    #1;
    chk("stall_idle", 64'(bus.stall), 64'h0);

    // Kill on r6, then underflow
    bus.issue_valid = 1'b1;
    bus.issue_wr_addr = 5'd6;
    #1;
    chk("r6_issue_accept", 64'(bus.issue_accept), 64'h1);
    step();
    bus.issue_wr_en = 1'b0;
    bus.rd_addr = {5'd0, 5'd6};
    bus.rd_used = 2'b01;
    bus.kill_valid = 1'b1;
    bus.kill_addr = 5'd6;
    #1;
    chk("r6_kill_same_cycle", 64'(bus.stall), 64'h1);
    step();
    bus.kill_valid = 1'b0;
    #1;
    chk("r6_unstalled", 64'(bus.stall), 64'h0);
    chk("r6_err_clear", 64'(bus.err_underflow), 64'h0);
    bus.issue_valid = 1'b0;
    bus.kill_valid = 1'b1;
    step();
    bus.kill_valid = 1'b0;
    chk("r6_err_set", 64'(bus.err_underflow), 64'h1);
    step();
    step();
    chk("r6_err_sticky", 64'(bus.err_underflow), 64'h1);

    // Same-cycle issue + writeback on r2, then mid-stream reset
    bus.issue_valid = 1'b1;
    bus.issue_wr_en = 1'b1;
    bus.issue_wr_addr = 5'd2;
    bus.rd_used = 2'b00;
    step();
    bus.wb_valid = 1'b1;
    bus.wb_addr = 5'd2;
    bus.wb_data = 32'h11;
    #1;
    chk("r2_issue_wb_accept", 64'(bus.issue_accept), 64'h1);
    step();
    bus.wb_valid = 1'b0;
    bus.issue_wr_en = 1'b0;
    bus.rd_addr = {5'd0, 5'd2};
    bus.rd_used = 2'b01;
    #1;
    chk("r2_cnt1_stall", 64'(bus.stall), 64'h1);
    bus.wb_valid = 1'b1;
    bus.wb_data = 32'h1234;
    #1;
    chk("r2_last_wb_stall", 64'(bus.stall), 64'h0);
    chk("r2_last_wb_data", 64'(bus.rd_data[31:0]), 64'h1234);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    bus.wb_valid = 1'b0;
    bus.rd_addr = {5'd3, 5'd2};
    bus.rd_used = 2'b11;
    #1;
    chk("post_rst_stall", 64'(bus.stall), 64'h0);
    chk("post_rst_rd_data", 64'(bus.rd_data), 64'h0);
    chk("post_rst_err", 64'(bus.err_underflow), 64'h0);
    bus.issue_wr_en = 1'b1;
    bus.issue_wr_addr = 5'd4;
    #1;
    chk("post_rst_r4_accept", 64'(bus.issue_accept), 64'h1);
    bus.issue_wr_en = 1'b0;

    // Register 0 is hardwired
    bus.wb_valid = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hFFFFFFFF;
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_no_bypass", 64'(bus.rd_data), 64'h0);
    chk("r0_no_stall", 64'(bus.stall), 64'h0);
    step();
    bus.wb_valid = 1'b0;
    #1;
    chk("r0_reads_zero", 64'(bus.rd_data), 64'h0);
    chk("r0_accept", 64'(bus.issue_accept), 64'h1);

    // Ten hazard stall cycles on r9
    bus.rd_used = 2'b00;
    bus.issue_wr_en = 1'b1;
    bus.issue_wr_addr = 5'd9;
    step();
    bus.issue_wr_en = 1'b0;
    bus.rd_addr = {5'd9, 5'd0};
    bus.rd_used = 2'b10;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("r9_stall", 64'(bus.stall), 64'h1);
      step();
    end
    bus.issue_valid = 1'b0;
    #1;
    chk("r9_idle", 64'(bus.stall), 64'h0);
`ifdef ID_SB_PERF_CNT_EN
    chk("perf_stall_cycles", 64'(stall_cycles), 64'd10);
    chk("perf_raw_stalls", 64'(raw_stalls), 64'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
